// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
package fwd_pkg;

  // Width of every "cycles until ready / needed" field.
  localparam int TNEW_W = 3;

  // Widest register address a slot can hold. Narrower addresses are zero-extended,
  // so the top-level AW parameter must not exceed this value.
  localparam int DST_MAX_W = 8;

  // One in-flight instruction: is it real, which register it writes, and how many
  // cycles remain until its result appears on that slot's stage_data lane.
  typedef struct packed {
    logic                 valid;
    logic [DST_MAX_W-1:0] dst;
    logic [TNEW_W-1:0]    tnew;
  } slot_t;

  // fwd_sel encodes 0 for the register file plus one code per slot.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a slot by one pipeline stage: one cycle closer to its result, never below zero.
  function automatic slot_t age_slot(input slot_t s);
    slot_t r;
    r = s;
    if (s.tnew != '0) begin
      r.tnew = s.tnew - TNEW_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port forwarding decision: youngest matching slot wins, then forward,
// fall back to the register file, or request a stall.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  slot_t [DEPTH-1:0]    i_slots,
  input  logic  [DEPTH*DW-1:0] i_stage_data,
  input  logic  [AW-1:0]       i_rd_addr,
  input  logic  [TNEW_W-1:0]   i_rd_tuse,
  input  logic  [DW-1:0]       i_rf_data,
  output logic  [DW-1:0]       o_fwd_data,
  output logic  [SEL_W-1:0]    o_fwd_sel,
  output logic                 o_stall_req
);

  logic              w_hit;
  int                w_idx;
  logic [TNEW_W-1:0] w_tnew;

  // Priority search: scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    // NOTE: every variable gets a value before any condition, otherwise a path that
    // skips an assignment would hold the old value and infer a latch.
    w_hit  = 1'b0;
    w_idx  = 0;
    w_tnew = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_slots[k].valid && (i_rd_addr != '0) &&
          (i_slots[k].dst == DST_MAX_W'(i_rd_addr))) begin
        w_hit  = 1'b1;
        w_idx  = k;
        w_tnew = i_slots[k].tnew;
      end
    end
  end

  // Operand mux and hazard check; a result not yet produced reads the register file but stalls
  // only if the consumer needs it sooner than the producer can deliver.
  always_comb begin
    o_fwd_sel   = '0;
    o_fwd_data  = i_rf_data;
    o_stall_req = 1'b0;
    if (w_hit) begin
      if (w_tnew == '0) begin
        o_fwd_sel  = SEL_W'(w_idx + 1);
        o_fwd_data = i_stage_data[w_idx*DW +: DW];
      end
      o_stall_req = (w_tnew > i_rd_tuse);
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks destination registers of in-flight instructions,
// selects bypass sources per read port and raises a pipeline stall on RAW hazards.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  localparam int SEL_W = sel_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_dst,
  input  logic [TNEW_W-1:0]       issue_tnew,
  input  logic                    flush,
  input  logic [DEPTH*DW-1:0]     stage_data,
  input  logic [NREAD*AW-1:0]     rd_addr,
  input  logic [NREAD*TNEW_W-1:0] rd_tuse,
  input  logic [NREAD*DW-1:0]     rf_data,
  output logic [NREAD*DW-1:0]     fwd_data,
  output logic [NREAD*SEL_W-1:0]  fwd_sel,
  output logic                    stall,
  output logic [15:0]             stall_cnt
);

  slot_t [DEPTH-1:0] r_slots;
  slot_t             w_issue_slot;
  logic [NREAD-1:0]  w_stall_req;

  // A stalled decode stage must not enter the pipe; it becomes a bubble instead.
  always_comb begin
    w_issue_slot = '0;
    if (issue_valid && !stall) begin
      w_issue_slot.valid = 1'b1;
      w_issue_slot.dst   = DST_MAX_W'(issue_dst);
      w_issue_slot.tnew  = issue_tnew;
    end
  end

  // Slot shift register: youngest enters slot 0, every slot ages one stage per edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: only DEPTH small slots exist, so they are cleared by reset directly; a
    // stale valid bit would otherwise forward garbage or stall forever after reset.
    if (!reset) begin
      r_slots <= '0;
    end else if (flush) begin
      r_slots <= '0;
    end else begin
      // NOTE: non-blocking assignments make every slot read its neighbour's old value,
      // which is what turns this loop into a shift rather than a ripple copy.
      r_slots[0] <= w_issue_slot;
      for (int k = 1; k < DEPTH; k++) begin
        r_slots[k] <= age_slot(r_slots[k-1]);
      end
    end
  end

  // One independent forwarding decision per read port.
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_port_sel #(
      .DW   (DW),
      .AW   (AW),
      .DEPTH(DEPTH),
      .SEL_W(SEL_W)
    ) u_port_sel (
      .i_slots     (r_slots),
      .i_stage_data(stage_data),
      .i_rd_addr   (rd_addr[p*AW +: AW]),
      .i_rd_tuse   (rd_tuse[p*TNEW_W +: TNEW_W]),
      .i_rf_data   (rf_data[p*DW +: DW]),
      .o_fwd_data  (fwd_data[p*DW +: DW]),
      .o_fwd_sel   (fwd_sel[p*SEL_W +: SEL_W]),
      .o_stall_req (w_stall_req[p])
    );
  end

  // Any port that cannot be satisfied in time holds the front end. Reset clears the slots
  // asynchronously, so stall falls as soon as reset is asserted.
  assign stall = |w_stall_req;

  // Saturating stalled-cycle counter for performance monitoring; flush does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed hazard scenarios, randomized traffic
// against a timestamp-based reference model, and stall counter saturation.
module tb_fwd_scoreboard;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;
  localparam int DEPTH = 7;
  localparam int TW    = 3;
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 issue_valid = 1'b0;
  logic [AW-1:0]        issue_dst = '0;
  logic [TW-1:0]        issue_tnew = '0;
  logic                 flush = 1'b0;
  logic [DEPTH*DW-1:0]  stage_data = '0;
  logic [NREAD*AW-1:0]  rd_addr = '0;
  logic [NREAD*TW-1:0]  rd_tuse = '0;
  logic [NREAD*DW-1:0]  rf_data = '0;
  logic [NREAD*DW-1:0]  fwd_data;
  logic [NREAD*SEL_W-1:0] fwd_sel;
  logic                 stall;
  logic [15:0]          stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .DW(DW), .AW(AW), .NREAD(NREAD), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_dst  (issue_dst),
    .issue_tnew (issue_tnew),
    .flush      (flush),
    .stage_data (stage_data),
    .rd_addr    (rd_addr),
    .rd_tuse    (rd_tuse),
    .rf_data    (rf_data),
    .fwd_data   (fwd_data),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  // Reference model: each accepted instruction is remembered with the edge number on which it
  // issued. Its age gives the slot it occupies, issue edge + tnew gives when its result is ready.
  typedef struct {
    int dst;
    int e;
    int t;
  } rec_t;

  rec_t           q[$];
  int             n_edge;
  int             m_cnt;
  int             m_sel[NREAD];
  logic [DW-1:0]  m_data[NREAD];
  bit             m_stall;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_eval();
    m_stall = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      int addr, tuse, best, age, rem;
      addr = int'(rd_addr[p*AW +: AW]);
      tuse = int'(rd_tuse[p*TW +: TW]);
      best = -1;
      // Queue is ordered by issue time, so the last match is the youngest.
      for (int i = 0; i < q.size(); i++) begin
        if (addr != 0 && q[i].dst == addr && (n_edge - q[i].e) < DEPTH) best = i;
      end
      m_sel[p]  = 0;
      m_data[p] = rf_data[p*DW +: DW];
      if (best >= 0) begin
        age = n_edge - q[best].e;
        rem = q[best].e + q[best].t - n_edge;
        if (rem < 0) rem = 0;
        if (rem == 0) begin
          m_sel[p]  = age + 1;
          m_data[p] = stage_data[age*DW +: DW];
        end
        if (rem > tuse) m_stall = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge();
    rec_t r;
    n_edge++;
    if (m_stall && m_cnt < 65535) m_cnt++;
    if (flush) begin
      q.delete();
    end else if (issue_valid && !m_stall) begin
      r.dst = int'(issue_dst);
      r.e   = n_edge;
      r.t   = int'(issue_tnew);
      q.push_back(r);
    end
    while (q.size() > 0 && (n_edge - q[0].e) >= DEPTH) void'(q.pop_front());
  endfunction

  // Called just after a rising edge with inputs already set: compare mid-cycle, then clock.
  task automatic tick(input bit do_check);
    #1;
    model_eval();
    if (do_check) begin
      for (int p = 0; p < NREAD; p++) begin
        check($sformatf("sel%0d", p), 64'(fwd_sel[p*SEL_W +: SEL_W]), 64'(m_sel[p]));
        check($sformatf("data%0d", p), 64'(fwd_data[p*DW +: DW]), 64'(m_data[p]));
      end
      check("stall", 64'(stall), 64'(m_stall));
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < DEPTH; k++) stage_data[k*DW +: DW] = $urandom();
    for (int p = 0; p < NREAD; p++) rf_data[p*DW +: DW] = $urandom();
  endtask

  task automatic set_idle();
    issue_valid = 1'b0;
    issue_dst   = '0;
    issue_tnew  = '0;
    flush       = 1'b0;
    rd_addr     = '0;
    rd_tuse     = '0;
    randomize_data();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    check("rst_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
    check("rst_data0", 64'(fwd_data[0 +: DW]), 64'(rf_data[0 +: DW]));
    q.delete();
    n_edge = 0;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int guard;

    #2;
    do_reset();

    // Single-cycle producer forwarded from slot 0.
    issue_valid = 1'b1; issue_dst = 5'd8; issue_tnew = 3'd0;
    tick(1);
    set_idle(); rd_addr[0 +: AW] = 5'd8;
    #1;
    check("d36_sel", 64'(fwd_sel[0 +: SEL_W]), 64'd1);
    check("d36_data", 64'(fwd_data[0 +: DW]), 64'(stage_data[0 +: DW]));
    tick(1);

    // Load-use: two stall cycles, then forward from slot 2.
    do_reset();
    issue_valid = 1'b1; issue_dst = 5'd9; issue_tnew = 3'd2;
    tick(1);
    set_idle(); rd_addr[0 +: AW] = 5'd9;
    #1;
    check("d37_stall1", 64'(stall), 64'd1);
    check("d37_sel1", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
    tick(1);
    #1;
    check("d37_stall2", 64'(stall), 64'd1);
    tick(1);
    #1;
    check("d37_stall3", 64'(stall), 64'd0);
    check("d37_sel3", 64'(fwd_sel[0 +: SEL_W]), 64'd3);
    check("d37_data3", 64'(fwd_data[0 +: DW]), 64'(stage_data[2*DW +: DW]));
    check("d37_cnt", 64'(stall_cnt), 64'd2);
    tick(1);

    // Two matches for the same register: the younger one in slot 0 decides.
    do_reset();
    issue_valid = 1'b1; issue_tnew = 3'd0;
    issue_dst = 5'd5; tick(1);
    issue_dst = 5'd6; tick(1);
    issue_dst = 5'd5; tick(1);
    set_idle(); rd_addr = {5'd5, 5'd5};
    #1;
    check("d38_sel0", 64'(fwd_sel[0 +: SEL_W]), 64'd1);
    check("d38_sel1", 64'(fwd_sel[SEL_W +: SEL_W]), 64'd1);
    tick(1);

    // Register 0 is never forwarded.
    do_reset();
    issue_valid = 1'b1; issue_dst = 5'd0; issue_tnew = 3'd0;
    tick(1);
    set_idle();
    #1;
    check("d39_sel", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
    check("d39_data", 64'(fwd_data[0 +: DW]), 64'(rf_data[0 +: DW]));
    check("d39_stall", 64'(stall), 64'd0);
    tick(1);

    // Flush kills a pending load so its consumer neither stalls nor forwards.
    do_reset();
    issue_valid = 1'b1; issue_dst = 5'd9; issue_tnew = 3'd2;
    tick(1);
    set_idle(); flush = 1'b1;
    tick(1);
    flush = 1'b0; rd_addr[0 +: AW] = 5'd9;
    #1;
    check("d40_stall", 64'(stall), 64'd0);
    check("d40_sel", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
    tick(1);

    // Randomized traffic on a small register set so hazards are frequent.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_dst   = AW'($urandom_range(0, 3));
      issue_tnew  = TW'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < NREAD; p++) begin
        rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3));
        rd_tuse[p*TW +: TW] = TW'($urandom_range(0, 2));
      end
      randomize_data();
      tick(1);
    end

    // Keep the pipe stalled as much as possible until the counter saturates.
    do_reset();
    issue_valid = 1'b1; issue_dst = 5'd1; issue_tnew = 3'd7;
    rd_addr[0 +: AW] = 5'd1;
    guard = 0;
    while (m_cnt < 65535 && guard < 90000) begin
      tick(guard % 4096 == 0);
      guard++;
    end
    for (int c = 0; c < 50; c++) tick(1);
    check("cnt_hold", 64'(stall_cnt), 64'hFFFF);

    // Assert reset mid-stall, between edges: stall and counter must fall at once.
    for (int c = 0; c < 16; c++) begin
      #1;
      model_eval();
      if (m_stall) break;
      tick(0);
    end
    check("pre_rst_stall", 64'(stall), 64'd1);
    reset = 1'b0;
    #1;
    check("async_rst_stall", 64'(stall), 64'd0);
    check("async_rst_cnt", 64'(stall_cnt), 64'd0);
    check("async_rst_sel", 64'(fwd_sel[0 +: SEL_W]), 64'd0);
    check("async_rst_data", 64'(fwd_data[0 +: DW]), 64'(rf_data[0 +: DW]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 The block SHALL have parameter DW, default 32, datapath width.
REQ-002 The block SHALL have parameter AW, default 5, register-address width.
REQ-003 The block SHALL have parameter NREAD, default 2, number of read ports (rs, rt, ...).
REQ-004 The block SHALL have parameter DEPTH, default 3, number of tracked in-flight slots (E, M, W).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous, active-low; 0 = reset.
REQ-007 The block SHALL have port issue_valid, input, 1, a decode-stage instruction enters slot 0 on this edge.
REQ-008 The block SHALL have port issue_dst, input, AW, destination register of the issuing instruction.
REQ-009 The block SHALL have port issue_tnew, input, 3, cycles until the issuing instruction's result is available.
REQ-010 The block SHALL have port flush, input, 1, synchronous invalidation of all slots.
REQ-011 The block SHALL have port stage_data, input, DEPTH*DW, result bus of slot k at bits [k*DW +: DW].
REQ-012 The block SHALL have port rd_addr, input, NREAD*AW, source register per read port.
REQ-013 The block SHALL have port rd_tuse, input, NREAD*3, cycles until each read port needs its operand.
REQ-014 The block SHALL have port rf_data, input, NREAD*DW, register-file read data per port.
REQ-015 The block SHALL have port fwd_data, output, NREAD*DW, forwarded operand per port.
REQ-016 The block SHALL have port fwd_sel, output, NREAD*($clog2(DEPTH+1)), 0 = register file, k+1 = slot k.
REQ-017 The block SHALL have port stall, output, 1, hold fetch/decode and insert a bubble.
REQ-018 The block SHALL have port stall_cnt, output, 16, saturating count of stalled cycles.

Function
REQ-019 Each slot SHALL hold {valid, dst, tnew}; slot 0 is youngest, slot DEPTH-1 oldest.
REQ-020 Each edge, slot k SHALL load slot k-1 with tnew decremented, saturating at 0; slot DEPTH-1 contents are discarded.
REQ-021 Slot 0 SHALL load {1, issue_dst, issue_tnew} when issue_valid=1 and stall=0, otherwise a bubble (valid=0).
REQ-022 flush=1 SHALL invalidate all slots on the edge, taking priority over issue and shift.
REQ-023 A slot SHALL match a read port when valid=1, dst==rd_addr and rd_addr!=0; register 0 never matches.
REQ-024 Per port, the youngest matching slot SHALL decide; older matches SHALL be ignored.
REQ-025 If the deciding slot has tnew==0, fwd_sel SHALL be k+1 and fwd_data SHALL equal slot k of stage_data.
REQ-026 If no slot matches, or the deciding slot has tnew>0, fwd_sel SHALL be 0 and fwd_data SHALL equal rf_data.
REQ-027 stall SHALL be 1 when any port's deciding slot has tnew > rd_tuse for that port.
REQ-028 fwd_sel, fwd_data and stall SHALL be combinational from current slot state and inputs, with zero-cycle latency.
REQ-029 stall_cnt SHALL increment on each edge where stall=1, saturate at 16'hFFFF, and be unaffected by flush.

Reset
REQ-030 While reset=0, all slots SHALL be invalid, with dst=0 and tnew=0.
REQ-031 While reset=0, stall_cnt SHALL be 0, so fwd_sel=0, fwd_data=rf_data and stall=0.
REQ-032 Reset asserted mid-stall SHALL drop stall in the same cycle without waiting for a clock edge.

Structure
REQ-033 Package fwd_pkg SHALL hold the slot struct type, the fwd_sel width function and the TNEW_W=3 constant.
REQ-034 Sub-module fwd_port_sel SHALL implement per-port priority match, mux and stall request.
REQ-035 fwd_port_sel SHALL be instantiated NREAD times; the top SHALL own the slot shift register, the stall OR and stall_cnt.

Verification
REQ-036 Issue dst=8 with tnew=0, then read rd_addr=8 with tuse=0 next cycle -> fwd_sel=1 and fwd_data=stage_data[slot0].
REQ-037 Issue dst=9 with tnew=2 (load), then read rd_addr=9 with tuse=0 -> stall=1 for 2 cycles; forwarding from slot 2 on the third cycle; stall_cnt=2.
REQ-038 Slots 0 and 2 both hold dst=5 with tnew=0 -> port reads slot 0, fwd_sel=1.
REQ-039 Issue dst=0 with tnew=0, then read rd_addr=0 -> fwd_sel=0, fwd_data=rf_data, stall=0.
REQ-040 Issue dst=9 with tnew=2, then assert flush on the next edge -> all slots invalid; read rd_addr=9 gives stall=0, fwd_sel=0.
REQ-041 Force stall for 70000 cycles, then assert reset=0 between edges -> stall_cnt holds at 16'hFFFF, then drops to 0 immediately.
